alu_pipe: RTL and testbench

Parametrised, handshaked successor to the team's single-cycle registered ALU in the math library. Accepts one operation per valid/ready transfer, produces a registered result plus zero/negative/carry/overflow flags, and holds it until the consumer takes it. Multiplication is a full-width iterative shift-add taking `dataSize` cycles; all other operations complete in one cycle. It sits between an operand-issue stage and a writeback stage, with back-pressure on both sides.

---
 rtl/alu_pipe_if.sv | 30 +++
 rtl/alu_pipe.sv | 165 ++++++++++++++++
 tb/tb_alu_pipe.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Handshake bus of alu_pipe: operand-issue side (in_*) and writeback side (out_*).
interface alu_pipe_if #(
  parameter int dataSize   = 8,
  parameter int opcodeSize = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [opcodeSize-1:0] func;
  logic [dataSize-1:0]   data1;
  logic [dataSize-1:0]   data2;
  logic                  out_valid;
  logic                  out_ready;
  logic [dataSize-1:0]   dataOut;
  logic                  zero;
  logic                  negative;
  logic                  carry;
  logic                  overflow;

  // Issue stage and writeback stage together drive the ALU
  modport master (
    output in_valid, func, data1, data2, out_ready,
    input  in_ready, out_valid, dataOut, zero, negative, carry, overflow
  );

  // The ALU itself
  modport slave (
    input  in_valid, func, data1, data2, out_ready,
    output in_ready, out_valid, dataOut, zero, negative, carry, overflow
  );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle logic/arith/shift ops, iterative shift-add
// multiply (dataSize cycles), registered result and flags held until taken.
module alu_pipe #(
  parameter int dataSize   = 8,
  parameter int opcodeSize = 4
) (
  input logic         clk,
  input logic         rst_n,
  alu_pipe_if.slave   bus
);
  localparam int N  = dataSize;
  localparam int SW = $clog2(dataSize);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_XNOR = 4'd6;
  localparam logic [3:0] OP_NAND = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_SLTU = 4'd12;
  localparam logic [3:0] OP_PASS = 4'd13;

  logic [1:0]          state;
  logic [SW-1:0]       step;
  logic [N-1:0]        mcand;
  logic [2*N-1:0]      prod;

  logic [3:0]          op;
  logic                accept;
  logic [N-1:0]        a, b;
  logic [SW-1:0]       shamt;
  logic [N:0]          sum_add, sum_sub;
  logic [N:0]          shl_w, shr_w;
  logic signed [N:0]   sra_w;
  logic [N-1:0]        res;
  logic                res_c, res_v;
  logic [N:0]          hi_sum;
  logic [2*N-1:0]      prod_nxt;

  assign op     = bus.func[3:0];
  assign accept = bus.in_valid && bus.in_ready;

  // Ready when idle, or when the held result leaves on this same edge
  assign bus.in_ready = rst_n && ((state == IDLE) || (state == HOLD && bus.out_ready));

  // Single-cycle datapath; shifts carry one extra bit so the last bit out lands in it
  always_comb begin
    a       = bus.data1;
    b       = bus.data2;
    shamt   = b[SW-1:0];
    sum_add = {1'b0, a} + {1'b0, b};
    sum_sub = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
    shl_w   = {1'b0, a} << shamt;
    shr_w   = {a, 1'b0} >> shamt;
    sra_w   = $signed({a, 1'b0}) >>> shamt;
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    case (op)
      OP_ADD: begin
        res   = sum_add[N-1:0];
        res_c = sum_add[N];
        res_v = (a[N-1] == b[N-1]) && (sum_add[N-1] != a[N-1]);
      end
      OP_SUB: begin
        res   = sum_sub[N-1:0];
        res_c = sum_sub[N];
        res_v = (a[N-1] != b[N-1]) && (sum_sub[N-1] != a[N-1]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b);
      OP_NAND: res = ~(a & b);
      OP_SHL: begin
        res   = shl_w[N-1:0];
        res_c = shl_w[N];
      end
      OP_SHR: begin
        res   = shr_w[N:1];
        res_c = shr_w[0];
      end
      OP_SRA: begin
        res   = sra_w[N:1];
        res_c = sra_w[0];
      end
      OP_SLT:  res = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: res = {{(N-1){1'b0}}, (a < b)};
      OP_PASS: res = b;
      default: res = '0;
    endcase
  end

  // One shift-add step: {hi, multiplier} shifts right, adding mcand into hi when LSB set
  always_comb begin
    hi_sum   = {1'b0, prod[2*N-1:N]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nxt = {hi_sum, prod[N-1:1]};
  end

  // Control FSM, multiply engine and registered result/flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      step          <= '0;
      mcand         <= '0;
      prod          <= '0;
      bus.out_valid <= 1'b0;
      bus.dataOut   <= '0;
      bus.zero      <= 1'b0;
      bus.negative  <= 1'b0;
      bus.carry     <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state         <= MUL;
              step          <= '0;
              mcand         <= bus.data1;
              prod          <= {{N{1'b0}}, bus.data2};
              bus.out_valid <= 1'b0;
            end else begin
              state         <= HOLD;
              bus.out_valid <= 1'b1;
              bus.dataOut   <= res;
              bus.zero      <= (res == '0);
              bus.negative  <= res[N-1];
              bus.carry     <= res_c;
              bus.overflow  <= res_v;
            end
          end else if (state == HOLD && bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        MUL: begin
          prod <= prod_nxt;
          step <= step + 1'b1;
          if (step == SW'(N - 1)) begin
            state         <= HOLD;
            step          <= '0;
            bus.out_valid <= 1'b1;
            bus.dataOut   <= prod_nxt[N-1:0];
            bus.zero      <= (prod_nxt[N-1:0] == '0);
            bus.negative  <= prod_nxt[N-1];
            bus.carry     <= |prod_nxt[2*N-1:N];
            bus.overflow  <= |prod_nxt[2*N-1:N];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed cases with literal expectations plus random
// traffic checked every cycle against a transaction-level model.
module tb_alu_pipe;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_pipe_if #(.dataSize(N), .opcodeSize(4)) bus ();

  alu_pipe #(.dataSize(N), .opcodeSize(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int res;
    bit c;
    bit v;
  } res_t;

  int   checks = 0;
  int   errors = 0;

  // Model: what the outputs must show after the next edge
  bit   m_valid;
  int   m_data;
  bit   m_z, m_n, m_c, m_v;
  int   m_cnt;
  res_t m_pend;
  bit   last_acc;

  function automatic res_t ref_alu(input int f, input int a, input int b);
    res_t r;
    int sa, sb, s, t;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    s  = b % 8;
    r.res = 0; r.c = 0; r.v = 0;
    case (f)
      0: begin t = a + b; r.res = t % 256; r.c = (t > 255); r.v = (sa + sb > 127) || (sa + sb < -128); end
      1: begin t = a - b; r.res = (t + 256) % 256; r.c = (a >= b); r.v = (sa - sb > 127) || (sa - sb < -128); end
      2: begin t = a * b; r.res = t % 256; r.c = (t >= 256); r.v = (t >= 256); end
      3: r.res = a & b;
      4: r.res = a | b;
      5: r.res = a ^ b;
      6: r.res = 255 - (a ^ b);
      7: r.res = 255 - (a & b);
      8: begin r.res = (a << s) % 256; r.c = (s != 0) && (((a >> (8 - s)) % 2) == 1); end
      9: begin r.res = a >> s; r.c = (s != 0) && (((a >> (s - 1)) % 2) == 1); end
      10: begin t = sa >>> s; r.res = (t + 256) % 256; r.c = (s != 0) && (((sa >>> (s - 1)) & 1) == 1); end
      11: r.res = (sa < sb) ? 1 : 0;
      12: r.res = (a < b) ? 1 : 0;
      13: r.res = b;
      default: r.res = 0;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input res_t r);
    m_data = r.res;
    m_z    = (r.res == 0);
    m_n    = (r.res >= 128);
    m_c    = r.c;
    m_v    = r.v;
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_cnt = 0;
  endtask

  task automatic compare_outputs();
    chk("out_valid", int'(bus.out_valid), int'(m_valid));
    chk("dataOut",   int'(bus.dataOut),   m_data);
    chk("zero",      int'(bus.zero),      int'(m_z));
    chk("negative",  int'(bus.negative),  int'(m_n));
    chk("carry",     int'(bus.carry),     int'(m_c));
    chk("overflow",  int'(bus.overflow),  int'(m_v));
  endtask

  // Called at posedge+1 with inputs already set; advances one clock
  task automatic tick();
    bit   exp_ready, acc, take;
    res_t r;
    #1;
    exp_ready = rst_n && (m_cnt == 0) && (!m_valid || bus.out_ready);
    chk("in_ready", int'(bus.in_ready), int'(exp_ready));
    acc  = bus.in_valid && exp_ready;
    take = m_valid && bus.out_ready;
    if (take) m_valid = 0;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        apply(m_pend);
        m_valid = 1;
      end
    end
    if (acc) begin
      r = ref_alu(int'(bus.func), int'(bus.data1), int'(bus.data2));
      if (bus.func == 4'd2) begin
        m_pend = r;
        m_cnt  = N;
      end else begin
        apply(r);
        m_valid = 1;
      end
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  // Issue one op, then hold the result with out_ready low; returns cycles to out_valid
  task automatic do_op(input int f, input int a, input int b, output int lat);
    int n;
    bus.in_valid  = 1'b1;
    bus.func      = 4'(f);
    bus.data1     = 8'(a);
    bus.data2     = 8'(b);
    bus.out_ready = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 50);
    chk("accept", int'(last_acc), 1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      bus.data1 = 8'($urandom);
      bus.data2 = 8'($urandom);
      tick();
      lat++;
    end
  endtask

  task automatic expect_lit(input string name, input int d, input int z, input int n,
                            input int c, input int v);
    chk({name, ".valid"}, int'(bus.out_valid), 1);
    chk({name, ".data"}, int'(bus.dataOut), d);
    chk({name, ".flags"}, int'({bus.zero, bus.negative, bus.carry, bus.overflow}),
        (z << 3) | (n << 2) | (c << 1) | v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    bus.in_valid = 1'b0; bus.func = '0; bus.data1 = '0; bus.data2 = '0; bus.out_ready = 1'b0;
    model_reset();
    last_acc = 0;
    m_pend.res = 0; m_pend.c = 0; m_pend.v = 0;

    // Reset state
    #12;
    chk("rst.in_ready", int'(bus.in_ready), 0);
    chk("rst.out_valid", int'(bus.out_valid), 0);
    chk("rst.dataOut", int'(bus.dataOut), 0);
    chk("rst.flags", int'({bus.zero, bus.negative, bus.carry, bus.overflow}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed single-cycle ops
    do_op(0, 8'hF0, 8'h20, lat); chk("add.lat", lat, 0); expect_lit("add", 8'h10, 0, 0, 1, 0);
    do_op(1, 8'h80, 8'h01, lat); expect_lit("sub1", 8'h7F, 0, 0, 1, 1);
    do_op(1, 8'h00, 8'h01, lat); expect_lit("sub2", 8'hFF, 0, 1, 0, 0);
    do_op(8, 8'h81, 8'h01, lat); expect_lit("shl", 8'h02, 0, 0, 1, 0);
    do_op(10, 8'h90, 8'h03, lat); expect_lit("sra", 8'hF2, 0, 1, 0, 0);
    do_op(9, 8'h90, 8'h04, lat); expect_lit("shr", 8'h09, 0, 0, 0, 0);
    do_op(11, 8'h80, 8'h01, lat); expect_lit("slt", 8'h01, 0, 0, 0, 0);
    do_op(12, 8'h80, 8'h01, lat); expect_lit("sltu", 8'h00, 1, 0, 0, 0);
    do_op(15, 8'h5A, 8'hA5, lat); expect_lit("rsvd", 8'h00, 1, 0, 0, 0);

    // Multiply latency and flags (operands scrambled while busy)
    do_op(2, 8'h13, 8'h11, lat); chk("mul.lat", lat, 8); expect_lit("mul1", 8'h43, 0, 0, 1, 1);
    do_op(2, 8'h00, 8'hFF, lat); chk("mul2.lat", lat, 8); expect_lit("mul2", 8'h00, 1, 0, 0, 0);

    // Back-pressure: hold result with a pending op for 5 cycles
    do_op(0, 8'h12, 8'h34, lat);
    bus.in_valid = 1'b1; bus.func = 4'd5; bus.data1 = 8'h0F; bus.data2 = 8'hFF;
    repeat (5) begin
      tick();
      chk("bp.in_ready", int'(bus.in_ready), 0);
      expect_lit("bp", 8'h46, 0, 0, 0, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp.accept", int'(last_acc), 1);
    expect_lit("bp.xor", 8'hF0, 0, 1, 0, 0);
    // Stream of 4 ADDs at one per cycle
    for (int i = 0; i < 4; i++) begin
      bus.func = 4'd0; bus.data1 = 8'(i + 1); bus.data2 = 8'(10 * i);
      tick();
      chk("stream.accept", int'(last_acc), 1);
      expect_lit("stream", 11 * i + 1, 0, 0, 0, 0);
    end
    bus.in_valid = 1'b0;
    tick();

    // Reset mid-multiply after 4 steps
    bus.in_valid = 1'b1; bus.func = 4'd2; bus.data1 = 8'h55; bus.data2 = 8'h37; bus.out_ready = 1'b1;
    tick();
    chk("rmul.accept", int'(last_acc), 1);
    bus.in_valid = 1'b0;
    repeat (4) tick();
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rmul.out_valid", int'(bus.out_valid), 0);
    chk("rmul.dataOut", int'(bus.dataOut), 0);
    chk("rmul.flags", int'({bus.zero, bus.negative, bus.carry, bus.overflow}), 0);
    chk("rmul.in_ready", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(0, 8'h01, 8'h01, lat); chk("post_rst.lat", lat, 0); expect_lit("post_rst", 8'h02, 0, 0, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.func      = 4'($urandom_range(0, 15));
      bus.data1     = 8'($urandom);
      bus.data2     = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
